bp_me_mem_cmd_responder: RTL and testbench

//  Memory-side end of the CCE-MEM interface. Accepts mem_cmd messages from a CCE (ready->valid),

---
 rtl/bp_me_mem_cmd_responder.sv | 182 ++++++++++++++++++
 tb/tb_bp_me_mem_cmd_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_mem_cmd_responder.sv
// Memory-side end of the CCE-MEM link: executes each mem_cmd as single-beat
// backing-store transfers and returns exactly one mem_resp per command.
module bp_me_mem_cmd_responder #(
   parameter int unsigned paddr_width_p  = 40,
   parameter int unsigned block_width_p  = 512,
   parameter int unsigned data_width_p   = 64,
   parameter int unsigned lce_id_width_p = 4,
   parameter int unsigned lce_assoc_p    = 8,
   localparam int unsigned msg_type_width_lp    = 2,
   localparam int unsigned size_width_lp        = 3,
   localparam int unsigned payload_width_lp     = lce_id_width_p + $clog2(lce_assoc_p),
   localparam int unsigned cce_mem_msg_width_lp = msg_type_width_lp + paddr_width_p + size_width_lp
                                                  + payload_width_lp + block_width_p
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
   input  logic                            mem_cmd_v_i,
   output logic                            mem_cmd_ready_o,
   output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
   output logic                            mem_resp_v_o,
   input  logic                            mem_resp_yumi_i,
   output logic                            mem_v_o,
   output logic                            mem_w_o,
   output logic [paddr_width_p-1:0]        mem_addr_o,
   output logic [data_width_p-1:0]         mem_data_o,
   output logic [data_width_p/8-1:0]       mem_mask_o,
   input  logic                            mem_ready_i,
   input  logic                            mem_data_v_i,
   input  logic [data_width_p-1:0]         mem_data_i
);
   localparam int unsigned bytes_lp     = data_width_p / 8;
   localparam int unsigned off_width_lp = $clog2(bytes_lp);
   localparam int unsigned beats_lp     = block_width_p / data_width_p;
   localparam int unsigned cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

   typedef enum logic [1:0] {
      e_cce_mem_rd    = 2'd0,
      e_cce_mem_wr    = 2'd1,
      e_cce_mem_uc_rd = 2'd2,
      e_cce_mem_uc_wr = 2'd3
   } msg_type_e;

   typedef struct packed {
      logic [msg_type_width_lp-1:0] msg_type;
      logic [paddr_width_p-1:0]     addr;
      logic [size_width_lp-1:0]     size;
      logic [payload_width_lp-1:0]  payload;
      logic [block_width_p-1:0]     data;
   } mem_msg_s;

   typedef enum logic [2:0] {READY, RD_REQ, RD_DATA, WR_REQ, RESP} state_e;

   state_e                                 r_state, w_state_n;
   mem_msg_s                               r_cmd, w_cmd_n, r_resp, w_resp_n;
   logic [cnt_width_lp-1:0]                r_cnt, w_cnt_n, r_last, w_last_n;
   logic [beats_lp-1:0][data_width_p-1:0]  r_beats, w_beats_n, w_blk;
   logic                                   r_cmd_ready, w_cmd_ready_n, r_resp_v, w_resp_v_n;
   logic                                   r_mem_v, w_mem_v_n, r_mem_w, w_mem_w_n;
   logic [paddr_width_p-1:0]               r_mem_addr, w_mem_addr_n, w_base;
   logic [data_width_p-1:0]                r_mem_data, w_mem_data_n;
   logic [bytes_lp-1:0]                    r_mem_mask, w_mem_mask_n, w_umask;
   logic [off_width_lp-1:0]                w_off;
   logic                                   w_cached;

   // Next state plus next registered outputs, derived from the post-transition state
   always_comb begin
      w_state_n    = r_state;
      w_cmd_n      = r_cmd;
      w_cnt_n      = r_cnt;
      w_last_n     = r_last;
      w_beats_n    = r_beats;
      w_resp_n     = r_resp;
      w_mem_data_n = '0;
      w_mem_mask_n = '0;
      w_umask      = '0;

      case (r_state)
         READY: if (mem_cmd_v_i) begin
            w_cmd_n  = mem_cmd_i;
            w_cnt_n  = '0;
            w_last_n = ((w_cmd_n.msg_type == e_cce_mem_rd) || (w_cmd_n.msg_type == e_cce_mem_wr))
                       ? cnt_width_lp'(beats_lp - 1) : '0;
            w_state_n = ((w_cmd_n.msg_type == e_cce_mem_rd) || (w_cmd_n.msg_type == e_cce_mem_uc_rd))
                        ? RD_REQ : WR_REQ;
         end
         RD_REQ: if (mem_ready_i) w_state_n = RD_DATA;
         RD_DATA: if (mem_data_v_i) begin
            w_beats_n[r_cnt] = mem_data_i;
            if (r_cnt == r_last) w_state_n = RESP;
            else begin
               w_cnt_n   = r_cnt + cnt_width_lp'(1);
               w_state_n = RD_REQ;
            end
         end
         WR_REQ: if (mem_ready_i) begin
            if (r_cnt == r_last) w_state_n = RESP;
            else w_cnt_n = r_cnt + cnt_width_lp'(1);
         end
         RESP: if (mem_resp_yumi_i) w_state_n = READY;
         default: w_state_n = READY;
      endcase

      w_cached = (w_cmd_n.msg_type == e_cce_mem_rd) || (w_cmd_n.msg_type == e_cce_mem_wr);
      w_base   = w_cached ? (w_cmd_n.addr & ~paddr_width_p'(block_width_p / 8 - 1))
                          : (w_cmd_n.addr & ~paddr_width_p'(bytes_lp - 1));
      w_off    = w_cmd_n.addr[off_width_lp-1:0];
      w_blk    = w_cmd_n.data;

      w_cmd_ready_n = (w_state_n == READY);
      w_mem_v_n     = (w_state_n == RD_REQ) || (w_state_n == WR_REQ);
      w_mem_w_n     = (w_state_n == WR_REQ);
      w_mem_addr_n  = w_mem_v_n ? (w_base + (paddr_width_p'(w_cnt_n) << off_width_lp)) : '0;
      w_resp_v_n    = (w_state_n == RESP);

      // Uncached writes place the low bytes of the payload at the address byte offset
      if (w_state_n == WR_REQ) begin
         if (w_cached) begin
            w_mem_data_n = w_blk[w_cnt_n];
            w_mem_mask_n = '1;
         end else begin
            if (w_cmd_n.size >= size_width_lp'(off_width_lp)) w_umask = '1;
            else w_umask = bytes_lp'((32'd1 << (32'd1 << w_cmd_n.size)) - 32'd1);
            w_mem_mask_n = w_umask << w_off;
            w_mem_data_n = w_cmd_n.data[data_width_p-1:0] << {w_off, 3'b000};
         end
      end

      if ((w_state_n == RESP) && (r_state != RESP)) begin
         w_resp_n = w_cmd_n;
         case (w_cmd_n.msg_type)
            e_cce_mem_rd:    w_resp_n.data = w_beats_n;
            e_cce_mem_uc_rd: w_resp_n.data = block_width_p'(w_beats_n[0]);
            default:         w_resp_n.data = '0;
         endcase
      end else if ((r_state == RESP) && mem_resp_yumi_i) begin
         w_resp_n = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= READY;
         r_cmd       <= '0;
         r_cnt       <= '0;
         r_last      <= '0;
         r_beats     <= '0;
         r_resp      <= '0;
         r_cmd_ready <= 1'b1;
         r_resp_v    <= 1'b0;
         r_mem_v     <= 1'b0;
         r_mem_w     <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_mem_mask  <= '0;
      end else begin
         r_state     <= w_state_n;
         r_cmd       <= w_cmd_n;
         r_cnt       <= w_cnt_n;
         r_last      <= w_last_n;
         r_beats     <= w_beats_n;
         r_resp      <= w_resp_n;
         r_cmd_ready <= w_cmd_ready_n;
         r_resp_v    <= w_resp_v_n;
         r_mem_v     <= w_mem_v_n;
         r_mem_w     <= w_mem_w_n;
         r_mem_addr  <= w_mem_addr_n;
         r_mem_data  <= w_mem_data_n;
         r_mem_mask  <= w_mem_mask_n;
      end
   end

   assign mem_cmd_ready_o = r_cmd_ready;
   assign mem_resp_o      = r_resp;
   assign mem_resp_v_o    = r_resp_v;
   assign mem_v_o         = r_mem_v;
   assign mem_w_o         = r_mem_w;
   assign mem_addr_o      = r_mem_addr;
   assign mem_data_o      = r_mem_data;
   assign mem_mask_o      = r_mem_mask;
endmodule

// File: tb/tb_bp_me_mem_cmd_responder.sv
// Scoreboard bench for bp_me_mem_cmd_responder: expected backing-store requests
// and responses are queued when commands are issued and checked as the DUT emits them.
`timescale 1ns/1ps
module tb_bp_me_mem_cmd_responder;
   localparam int unsigned PA = 40;
   localparam int unsigned BW = 512;
   localparam int unsigned DW = 64;
   localparam int unsigned MW = 2 + PA + 3 + 7 + BW;
   localparam logic [1:0] T_RD = 2'd0, T_WR = 2'd1, T_UCRD = 2'd2, T_UCWR = 2'd3;

   typedef struct packed {
      logic [1:0]    t;
      logic [PA-1:0] addr;
      logic [2:0]    size;
      logic [6:0]    payload;
      logic [BW-1:0] data;
   } msg_t;

   typedef struct packed {
      logic          w;
      logic [PA-1:0] addr;
      logic [DW-1:0] data;
      logic [7:0]    mask;
   } req_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [MW-1:0] mem_cmd_i = '0;
   logic          mem_cmd_v_i = 1'b0;
   logic          mem_cmd_ready_o;
   logic [MW-1:0] mem_resp_o;
   logic          mem_resp_v_o;
   logic          mem_resp_yumi_i = 1'b0;
   logic          mem_v_o, mem_w_o;
   logic [PA-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_o;
   logic [7:0]    mem_mask_o;
   logic          mem_ready_i = 1'b1;
   logic          mem_data_v_i = 1'b0;
   logic [DW-1:0] mem_data_i = '0;

   int   n_tot = 0, n_bad = 0, n_resp = 0, n_beats = 0;
   req_t exp_mem[$];
   msg_t exp_resp[$];
   req_t e_req;
   logic pend_rd = 1'b0, spur = 1'b0, rand_ready = 1'b0, hold_yumi = 1'b0;
   logic [PA-1:0] pend_addr = '0;

   bp_me_mem_cmd_responder dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
      .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i),
      .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_mask_o(mem_mask_o), .mem_ready_i(mem_ready_i), .mem_data_v_i(mem_data_v_i),
      .mem_data_i(mem_data_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [PA-1:0] a);
      return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
   endfunction

   function automatic msg_t mk(input logic [1:0] t, input logic [PA-1:0] a, input logic [2:0] sz,
                               input logic [6:0] pl, input logic [BW-1:0] d);
      msg_t m;
      m.t = t; m.addr = a; m.size = sz; m.payload = pl; m.data = d;
      return m;
   endfunction

   // Cached read: 8 block-aligned beats, response carries the beats in order
   task automatic exp_cached_rd(input msg_t m);
      logic [PA-1:0] base;
      msg_t r;
      base = m.addr & ~PA'(64'h3F);
      r = m;
      for (int i = 0; i < 8; i++) begin
         exp_mem.push_back('{w: 1'b0, addr: base + PA'(8 * i), data: '0, mask: '0});
         r.data[64*i +: 64] = mem_word(base + PA'(8 * i));
      end
      exp_resp.push_back(r);
   endtask

   task automatic exp_cached_wr(input msg_t m);
      logic [PA-1:0] base;
      msg_t r;
      base = m.addr & ~PA'(64'h3F);
      for (int i = 0; i < 8; i++)
         exp_mem.push_back('{w: 1'b1, addr: base + PA'(8 * i), data: m.data[64*i +: 64], mask: 8'hFF});
      r = m; r.data = '0;
      exp_resp.push_back(r);
   endtask

   task automatic exp_uc_rd(input msg_t m);
      logic [PA-1:0] a;
      msg_t r;
      a = m.addr & ~PA'(64'h7);
      exp_mem.push_back('{w: 1'b0, addr: a, data: '0, mask: '0});
      r = m; r.data = '0; r.data[63:0] = mem_word(a);
      exp_resp.push_back(r);
   endtask

   task automatic send(input msg_t m, input int lat);
      int k;
      k = 0;
      while (!mem_cmd_ready_o && k < 200) begin @(posedge clk); #1; k++; end
      chk("cmd_ready_wait", mem_cmd_ready_o, 1'b1);
      mem_cmd_i = m; mem_cmd_v_i = 1'b1;
      @(posedge clk); #1;
      mem_cmd_v_i = 1'b0; mem_cmd_i = '0;
      k = 1;
      while (!mem_resp_v_o && k < 300) begin @(posedge clk); #1; k++; end
      if (lat > 0) chk("latency", MW'(k), MW'(lat));
      else chk("resp_seen", mem_resp_v_o, 1'b1);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((exp_resp.size() != 0 || exp_mem.size() != 0) && k < 500) begin @(posedge clk); #1; k++; end
      chk("idle_timeout", MW'(k >= 500), '0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, mem_cmd_ready_o, 1'b1);
      chk({tag, "_mem_v"}, mem_v_o, 1'b0);
      chk({tag, "_mem_w"}, mem_w_o, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr_o, '0);
      chk({tag, "_mem_data"}, mem_data_o, '0);
      chk({tag, "_mem_mask"}, mem_mask_o, '0);
      chk({tag, "_resp_v"}, mem_resp_v_o, 1'b0);
      chk({tag, "_resp"}, mem_resp_o, '0);
   endtask

   // Environment: checks outputs at negedge, then drives memory/yumi after posedge
   initial begin : env
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mem_v_o) begin
               if (exp_mem.size() == 0) chk("mem_unexpected", 1'b1, 1'b0);
               else begin
                  e_req = exp_mem[0];
                  chk("mem_w", mem_w_o, e_req.w);
                  chk("mem_addr", mem_addr_o, e_req.addr);
                  if (e_req.w) begin
                     chk("mem_data", mem_data_o, e_req.data);
                     chk("mem_mask", mem_mask_o, e_req.mask);
                  end
                  if (mem_ready_i) begin
                     void'(exp_mem.pop_front());
                     if (!mem_w_o) begin pend_rd = 1'b1; pend_addr = mem_addr_o; end
                  end
               end
            end
            if (mem_resp_v_o) begin
               chk("cmd_ready_in_resp", mem_cmd_ready_o, 1'b0);
               if (exp_resp.size() == 0) chk("resp_unexpected", 1'b1, 1'b0);
               else begin
                  chk("resp", mem_resp_o, exp_resp[0]);
                  if (mem_resp_yumi_i) begin void'(exp_resp.pop_front()); n_resp++; end
               end
            end
         end
         @(posedge clk); #1;
         mem_data_v_i = 1'b0; mem_data_i = '0;
         if (pend_rd) begin
            mem_data_v_i = 1'b1; mem_data_i = mem_word(pend_addr); pend_rd = 1'b0; n_beats++;
         end else if (spur) begin
            mem_data_v_i = 1'b1; mem_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
         end
         mem_ready_i     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         mem_resp_yumi_i = mem_resp_v_o && !hold_yumi;
      end
   end

   initial begin : main
      msg_t m, r;
      logic [BW-1:0] blk;

      repeat (2) @(posedge clk);
      #1 chk_reset_outputs("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Uncached 2-byte write at byte offset 3
      m = mk(T_UCWR, 40'h80_0000_0013, 3'd1, 7'h15, BW'(64'hBEEF));
      exp_mem.push_back('{w: 1'b1, addr: 40'h80_0000_0010, data: 64'h0000_00BE_EF00_0000, mask: 8'h18});
      r = m; r.data = '0; exp_resp.push_back(r);
      send(m, 2);
      wait_idle();

      // Cached block read, zero-wait memory
      m = mk(T_RD, 40'h80_0000_0048, 3'd6, 7'h2A, '0);
      exp_cached_rd(m);
      send(m, 17);
      wait_idle();

      m = mk(T_UCRD, 40'h80_0000_0123, 3'd2, 7'h07, '0);
      exp_uc_rd(m);
      send(m, 3);
      wait_idle();

      for (int i = 0; i < BW / 32; i++) blk[32*i +: 32] = $urandom;
      m = mk(T_WR, 40'h80_0000_1000, 3'd6, 7'h33, blk);
      exp_cached_wr(m);
      send(m, 9);
      wait_idle();

      // Cached write with random backing-store stalls
      rand_ready = 1'b1;
      for (int i = 0; i < BW / 32; i++) blk[32*i +: 32] = $urandom;
      m = mk(T_WR, 40'h80_0000_2038, 3'd6, 7'h41, blk);
      exp_cached_wr(m);
      send(m, 0);
      wait_idle();
      rand_ready = 1'b0;
      chk("resp_count_after_stall_wr", MW'(n_resp), MW'(5));

      // Response back-pressure
      hold_yumi = 1'b1;
      m = mk(T_UCRD, 40'h80_0000_0208, 3'd3, 7'h5C, '0);
      exp_uc_rd(m);
      send(m, 3);
      repeat (10) @(posedge clk);
      #1 chk("resp_v_held", mem_resp_v_o, 1'b1);
      hold_yumi = 1'b0;
      wait_idle();

      // Spurious read-data valids outside RD_DATA
      spur = 1'b1;
      m = mk(T_UCRD, 40'h80_0000_0300, 3'd3, 7'h11, '0);
      exp_uc_rd(m);
      send(m, 3);
      wait_idle();
      m = mk(T_UCWR, 40'h80_0000_0305, 3'd0, 7'h12, BW'(64'h5A));
      exp_mem.push_back('{w: 1'b1, addr: 40'h80_0000_0300, data: 64'h0000_5A00_0000_0000, mask: 8'h20});
      r = m; r.data = '0; exp_resp.push_back(r);
      send(m, 2);
      wait_idle();
      spur = 1'b0;

      // Reset in the middle of a cached read, after the third beat returns
      m = mk(T_RD, 40'h80_0000_0400, 3'd6, 7'h01, '0);
      exp_cached_rd(m);
      n_beats = 0;
      mem_cmd_i = m; mem_cmd_v_i = 1'b1;
      @(posedge clk); #1;
      mem_cmd_v_i = 1'b0; mem_cmd_i = '0;
      for (int k = 0; k < 100 && n_beats < 3; k++) begin @(posedge clk); #1; end
      chk("beats_before_reset", MW'(n_beats), MW'(3));
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid");
      exp_mem.delete(); exp_resp.delete(); pend_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      m = mk(T_UCRD, 40'h80_0000_0510, 3'd3, 7'h3F, '0);
      exp_uc_rd(m);
      send(m, 3);
      wait_idle();

      chk("resp_count_total", MW'(n_resp), MW'(9));
      chk("queues_empty", MW'(exp_mem.size() + exp_resp.size()), '0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
